cardinal_processor: RTL and testbench

- Pipelined 64-bit SIMD ("variable-width") load/store processor core with 32 x 64-bit registers, 32-bit instructions and 8-bit instruction/data addresses.
- Connects to an external combinational instruction memory (256 x 32) and an external data memory (256 x 64) that writes on the clock edge.
- The top level instantiates the core, the memories and a cycle counter. The register file instance is named rf, with its array named data_arr[0:31].

---
 rtl/cardinal_processor.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cardinal_processor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_processor.sv
// cardinal_processor: 4-stage (IF/ID/EXM/WB) 64-bit SIMD load/store core.
// Ports: Clock, Reset (sync, high); Instr_Addr/Instruction to imem;
//   Mem_Addr, Data_Out, Data_In, DmemEn, DmemWrEn to dmem.
// ISA bit n (big-endian, 0 = MSB) lives at vector index [W-1-n].

module cardinal_rf (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [63:0] wd,
   input  logic [4:0]  ra_a,
   input  logic [4:0]  ra_b,
   input  logic [4:0]  ra_d,
   output logic [63:0] q_a,
   output logic [63:0] q_b,
   output logic [63:0] q_d
);
   logic [63:0] data_arr [0:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) data_arr[i] <= '0;
      end else if (we) begin
         data_arr[wa] <= wd;
      end
   end

   assign q_a = data_arr[ra_a];
   assign q_b = data_arr[ra_b];
   assign q_d = data_arr[ra_d];
endmodule

module cardinal_processor (
   input  logic        Clock,
   input  logic        Reset,
   output logic [7:0]  Instr_Addr,
   input  logic [31:0] Instruction,
   output logic [7:0]  Mem_Addr,
   output logic [63:0] Data_Out,
   input  logic [63:0] Data_In,
   output logic        DmemEn,
   output logic        DmemWrEn
);
   localparam logic [5:0] OP_R    = 6'b101010;
   localparam logic [5:0] OP_VLD  = 6'b100000;
   localparam logic [5:0] OP_VSD  = 6'b100001;
   localparam logic [5:0] OP_BEZ  = 6'b100010;
   localparam logic [5:0] OP_BNEZ = 6'b100011;

   typedef struct packed {
      logic        wr;
      logic        ld;
      logic        st;
      logic [4:0]  rd;
      logic [7:0]  be;
      logic [1:0]  ww;
      logic [5:0]  func;
      logic [7:0]  addr;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] d;
   } id_ex_t;

   typedef struct packed {
      logic        wr;
      logic [4:0]  rd;
      logic [63:0] res;
   } ex_wb_t;

   logic [7:0]  pc;
   logic [31:0] if_id;
   id_ex_t      id_ex, id_ex_n;
   ex_wb_t      ex_wb;

   // ---------------- ID ----------------
   logic [5:0]  op, func;
   logic [4:0]  rd, ra, rb;
   logic [2:0]  ppp;
   logic [1:0]  ww;
   logic [7:0]  addr, be;
   logic [63:0] q_a, q_b, q_d;
   logic [63:0] a_val, b_val, d_val, ex_res;
   logic        is_r, is_ld, is_st, fn_ok, taken;

   assign op   = if_id[31:26];
   assign rd   = if_id[25:21];
   assign ra   = if_id[20:16];
   assign rb   = if_id[15:11];
   assign ppp  = if_id[10:8];
   assign ww   = if_id[7:6];
   assign func = if_id[5:0];
   assign addr = if_id[7:0];

   cardinal_rf rf (
      .clk  (Clock),
      .rst  (Reset),
      .we   (ex_wb.wr),
      .wa   (ex_wb.rd),
      .wd   (ex_wb.res),
      .ra_a (ra),
      .ra_b (rb),
      .ra_d (rd),
      .q_a  (q_a),
      .q_b  (q_b),
      .q_d  (q_d)
   );

   // Later assignment wins: EXM result beats WB beats regfile.
   always_comb begin
      a_val = q_a;
      b_val = q_b;
      d_val = q_d;
      if (ex_wb.wr && ex_wb.rd == ra) a_val = ex_wb.res;
      if (ex_wb.wr && ex_wb.rd == rb) b_val = ex_wb.res;
      if (ex_wb.wr && ex_wb.rd == rd) d_val = ex_wb.res;
      if (id_ex.wr && id_ex.rd == ra) a_val = ex_res;
      if (id_ex.wr && id_ex.rd == rb) b_val = ex_res;
      if (id_ex.wr && id_ex.rd == rd) d_val = ex_res;
   end

   // Byte enables, index 7 = big-endian byte 0.
   always_comb begin
      be = 8'h00;
      case (ppp)
         3'b000:  be = 8'hFF;
         3'b001:  be = 8'hF0;
         3'b010:  be = 8'h0F;
         3'b011:  be = 8'hAA;
         3'b100:  be = 8'h55;
         default: be = 8'h00;
      endcase
   end

   assign is_r  = op == OP_R;
   assign is_ld = op == OP_VLD;
   assign is_st = op == OP_VSD;
   assign fn_ok = func >= 6'd1 && func <= 6'd13;
   assign taken = (op == OP_BEZ  && d_val == '0) ||
                  (op == OP_BNEZ && d_val != '0);

   always_comb begin
      id_ex_n      = '0;
      id_ex_n.wr   = (is_r && fn_ok && be != 8'h00) || is_ld;
      id_ex_n.ld   = is_ld;
      id_ex_n.st   = is_st;
      id_ex_n.rd   = rd;
      id_ex_n.be   = is_ld ? 8'hFF : be;
      id_ex_n.ww   = ww;
      id_ex_n.func = func;
      id_ex_n.addr = addr;
      id_ex_n.a    = a_val;
      id_ex_n.b    = b_val;
      id_ex_n.d    = d_val;
   end

   // ---------------- EXM ----------------
   // One lane of width w, zero-extended into 64 bits.
   function automatic logic [63:0] lane_alu(
      input logic [5:0]  f,
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [6:0]  w
   );
      logic [63:0] m, s, r;
      logic [5:0]  sh, hw;
      m  = (w == 7'd64) ? '1 : (64'd1 << w) - 64'd1;
      sh = b[5:0] & 6'(w - 7'd1);
      hw = 6'(w >> 1);
      s  = a[6'(w - 7'd1)] ? (a | ~m) : a;
      case (f)
         6'd1:    r = a & b;
         6'd2:    r = a | b;
         6'd3:    r = a ^ b;
         6'd4:    r = ~a;
         6'd5:    r = a;
         6'd6:    r = a + b;
         6'd7:    r = a - b;
         6'd10:   r = a << sh;
         6'd11:   r = a >> sh;
         6'd12:   r = $signed(s) >>> sh;
         6'd13:   r = (a << hw) | (a >> hw);
         default: r = '0;
      endcase
      return r & m;
   endfunction

   logic [63:0] xa, xb, alu, bm;
   logic        mul, odd;

   assign xa  = id_ex.a;
   assign xb  = id_ex.b;
   assign mul = id_ex.func == 6'd8 || id_ex.func == 6'd9;
   assign odd = id_ex.func == 6'd9;

   // Multiplies: the even lane of a pair is its upper half.
   always_comb begin
      alu = '0;
      unique case (id_ex.ww)
         2'b00:
            if (mul)
               for (int q = 0; q < 4; q++)
                  alu[16*q +: 16] =
                     16'(xa[16*q + (odd ? 0 : 8) +: 8]) *
                     16'(xb[16*q + (odd ? 0 : 8) +: 8]);
            else
               for (int i = 0; i < 8; i++)
                  alu[8*i +: 8] = 8'(lane_alu(id_ex.func,
                     64'(xa[8*i +: 8]), 64'(xb[8*i +: 8]), 7'd8));
         2'b01:
            if (mul)
               for (int q = 0; q < 2; q++)
                  alu[32*q +: 32] =
                     32'(xa[32*q + (odd ? 0 : 16) +: 16]) *
                     32'(xb[32*q + (odd ? 0 : 16) +: 16]);
            else
               for (int i = 0; i < 4; i++)
                  alu[16*i +: 16] = 16'(lane_alu(id_ex.func,
                     64'(xa[16*i +: 16]), 64'(xb[16*i +: 16]), 7'd16));
         2'b10:
            if (mul)
               alu = 64'(xa[(odd ? 0 : 32) +: 32]) *
                     64'(xb[(odd ? 0 : 32) +: 32]);
            else
               for (int i = 0; i < 2; i++)
                  alu[32*i +: 32] = 32'(lane_alu(id_ex.func,
                     64'(xa[32*i +: 32]), 64'(xb[32*i +: 32]), 7'd32));
         2'b11:
            if (!mul)
               alu = lane_alu(id_ex.func, xa, xb, 7'd64);
      endcase
   end

   always_comb begin
      bm = '0;
      for (int j = 0; j < 8; j++) bm[8*j +: 8] = {8{id_ex.be[j]}};
   end

   // Merge keeps unselected bytes so forwarded values are whole.
   assign ex_res = id_ex.ld ? Data_In : ((alu & bm) | (id_ex.d & ~bm));

   assign DmemEn     = id_ex.ld | id_ex.st;
   assign DmemWrEn   = id_ex.st;
   assign Mem_Addr   = DmemEn ? id_ex.addr : '0;
   assign Data_Out   = id_ex.st ? id_ex.d : '0;
   assign Instr_Addr = pc;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc    <= '0;
         if_id <= '0;
         id_ex <= '0;
         ex_wb <= '0;
      end else begin
         pc        <= taken ? addr : pc + 8'd1;
         if_id     <= taken ? '0 : Instruction;
         id_ex     <= id_ex_n;
         ex_wb.wr  <= id_ex.wr;
         ex_wb.rd  <= id_ex.rd;
         ex_wb.res <= ex_res;
      end
   end
endmodule

// File: tb/tb_cardinal_processor.sv
// tb_cardinal_processor: directed and random programs against an
// instruction-level ISA model; checks registers, memory, dmem strobes.

module tb_cardinal_processor;
   localparam logic [5:0] OP_R    = 6'b101010;
   localparam logic [5:0] OP_VLD  = 6'b100000;
   localparam logic [5:0] OP_VSD  = 6'b100001;
   localparam logic [5:0] OP_BEZ  = 6'b100010;
   localparam logic [5:0] OP_BNEZ = 6'b100011;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  Instr_Addr, Mem_Addr;
   logic [31:0] Instruction;
   logic [63:0] Data_Out, Data_In;
   logic        DmemEn, DmemWrEn;

   logic [31:0] imem [0:255];
   logic [63:0] dmem [0:255];
   logic [63:0] mreg [0:31];
   logic [63:0] mmem [0:255];
   int          mstores, mmemops;

   int checks = 0, errors = 0;
   int wr_cnt, en_cnt, bad_cnt;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  trace [$];

   always #5 clk = ~clk;

   cardinal_processor dut (
      .Clock       (clk),
      .Reset       (Reset),
      .Instr_Addr  (Instr_Addr),
      .Instruction (Instruction),
      .Mem_Addr    (Mem_Addr),
      .Data_Out    (Data_Out),
      .Data_In     (Data_In),
      .DmemEn      (DmemEn),
      .DmemWrEn    (DmemWrEn)
   );

   assign Instruction = imem[Instr_Addr];
   assign Data_In     = dmem[Mem_Addr];

   always @(posedge clk)
      if (DmemEn && DmemWrEn) dmem[Mem_Addr] = Data_Out;

   always @(negedge clk)
      if (!Reset) begin
         trace.push_back(Instr_Addr);
         if (DmemEn) en_cnt++;
         if (DmemWrEn) begin
            wr_cnt++;
            wr_addr = Mem_Addr;
            wr_data = Data_Out;
         end
         if (!DmemEn && (Mem_Addr != 0 || Data_Out != 0 || DmemWrEn))
            bad_cnt++;
      end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] lmask(input int w);
      return (w == 64) ? '1 : (64'd1 << w) - 64'd1;
   endfunction

   // Lane k counted from the most significant end.
   function automatic logic [63:0] lget(input logic [63:0] v,
                                        input int w, input int k);
      return (v >> (64 - w*(k+1))) & lmask(w);
   endfunction

   function automatic logic [63:0] lput(input logic [63:0] v, input int w,
                                        input int k, input logic [63:0] x);
      int sh = 64 - w*(k+1);
      return (v & ~(lmask(w) << sh)) | ((x & lmask(w)) << sh);
   endfunction

   function automatic logic [63:0] model_r(
      input logic [5:0] fn, input logic [2:0] ppp, input logic [1:0] ww,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] d);
      int w = 8 << ww;
      int n = 64 / w;
      int s;
      bit on;
      logic [63:0] r = '0, x, y, v, res = d;
      if (fn < 1 || fn > 13 || ppp > 4) return d;
      if (fn == 8 || fn == 9) begin
         if (w < 64)
            for (int p = 0; p < n/2; p++) begin
               x = lget(a, w, 2*p + int'(fn == 9));
               y = lget(b, w, 2*p + int'(fn == 9));
               r = lput(r, 2*w, p, x * y);
            end
      end else begin
         for (int k = 0; k < n; k++) begin
            x = lget(a, w, k);
            y = lget(b, w, k);
            s = int'(y % w);
            case (fn)
               1:  v = x & y;
               2:  v = x | y;
               3:  v = x ^ y;
               4:  v = ~x;
               5:  v = x;
               6:  v = x + y;
               7:  v = x - y;
               10: v = x << s;
               11: v = x >> s;
               12: begin
                  v = x >> s;
                  if ((x >> (w-1)) & 1) v = v | (lmask(w) & ~(lmask(w) >> s));
               end
               default: v = (x << (w/2)) | (x >> (w/2));
            endcase
            r = lput(r, w, k, v);
         end
      end
      for (int k = 0; k < 8; k++) begin
         case (ppp)
            0: on = 1;
            1: on = k < 4;
            2: on = k >= 4;
            3: on = (k % 2) == 0;
            default: on = (k % 2) == 1;
         endcase
         if (on) res = lput(res, 8, k, lget(r, 8, k));
      end
      return res;
   endfunction

   task automatic model_run(input int halt);
      int pc = 0;
      int steps = 0;
      logic [31:0] w;
      logic [5:0] op;
      logic [4:0] rd;
      logic [7:0] ad;
      int np;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      mstores = 0;
      mmemops = 0;
      while (pc != halt && steps < 1000) begin
         w  = imem[pc];
         op = w[31:26];
         rd = w[25:21];
         ad = w[7:0];
         np = (pc + 1) % 256;
         case (op)
            OP_R: mreg[rd] = model_r(w[5:0], w[10:8], w[7:6],
                                     mreg[w[20:16]], mreg[w[15:11]], mreg[rd]);
            OP_VLD: begin
               mreg[rd] = mmem[ad];
               mmemops++;
            end
            OP_VSD: begin
               mmem[ad] = mreg[rd];
               mstores++;
               mmemops++;
            end
            OP_BEZ:  if (mreg[rd] == 0) np = ad;
            OP_BNEZ: if (mreg[rd] != 0) np = ad;
            default: ;
         endcase
         pc = np;
         steps++;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] rty(input logic [4:0] d, a, b,
      input logic [2:0] p, input logic [1:0] ww, input logic [5:0] f);
      return {OP_R, d, a, b, p, ww, f};
   endfunction

   function automatic logic [31:0] mty(input logic [5:0] op,
      input logic [4:0] d, input logic [7:0] ad);
      return {op, d, 13'd0, ad};
   endfunction

   function automatic logic [31:0] rand_ins(input int pc, input int n);
      int c = $urandom_range(0, 99);
      logic [4:0] rd = 5'($urandom_range(0, 30));
      logic [4:0] rs = 5'($urandom_range(0, 31));
      logic [7:0] ad = 8'($urandom_range(0, 15));
      if (c < 55)
         return {OP_R, rd, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 5)),
                 2'($urandom), 6'($urandom_range(0, 15))};
      if (c < 70) return {OP_VLD, rd, 13'($urandom), ad};
      if (c < 82) return {OP_VSD, rs, 13'($urandom), ad};
      if (c < 92)
         return mty(($urandom & 1) ? OP_BEZ : OP_BNEZ, rs,
                    8'($urandom_range(pc + 1, n)));
      return ($urandom & 1) ? 32'h0 : {6'b111100, 26'($urandom)};
   endfunction

   task automatic load_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = '0;
         dmem[i] = {$urandom, $urandom};
      end
   endtask

   task automatic gen_prog(output int halt);
      int n = $urandom_range(20, 40);
      load_mem();
      for (int i = 0; i < n; i++) imem[i] = rand_ins(i, n);
      imem[n] = mty(OP_BEZ, 5'd31, 8'(n));
      halt = n;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 Reset = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_pc", 64'(Instr_Addr), 64'd0);
      check("rst_en", 64'({DmemEn, DmemWrEn}), 64'd0);
      for (int i = 0; i < 32; i++)
         check($sformatf("rst_r%0d", i), dut.rf.data_arr[i], 64'd0);
   endtask

   task automatic release_run(input int ncyc);
      wr_cnt  = 0;
      en_cnt  = 0;
      bad_cnt = 0;
      trace.delete();
      @(negedge clk);
      #1 Reset = 1'b0;
      repeat (ncyc) @(negedge clk);
      #1;
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 32; i++)
         check($sformatf("%s_r%0d", tag, i), dut.rf.data_arr[i], mreg[i]);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s_m%0d", tag, i), dmem[i], mmem[i]);
      check({tag, "_stores"}, 64'(wr_cnt), 64'(mstores));
      check({tag, "_memops"}, 64'(en_cnt), 64'(mmemops));
      check({tag, "_idle_bus"}, 64'(bad_cnt), 64'd0);
   endtask

   initial begin
      int halt;

      // Directed program.
      do_reset();
      load_mem();
      dmem[0] = 64'h0102030405060708;
      dmem[1] = 64'h0101010101010101;
      dmem[2] = 64'hAAAAAAAAAAAAAAAA;
      dmem[3] = 64'hFFFFFFFFFFFFFFFF;
      dmem[4] = 64'h0000000000000001;
      imem[0]  = mty(OP_VLD, 5'd1, 8'd0);
      imem[1]  = mty(OP_VLD, 5'd2, 8'd1);
      imem[2]  = rty(5'd3, 5'd1, 5'd2, 3'd0, 2'b00, 6'd6);
      imem[3]  = mty(OP_VSD, 5'd3, 8'd5);
      imem[4]  = mty(OP_VLD, 5'd4, 8'd2);
      imem[5]  = rty(5'd4, 5'd1, 5'd0, 3'd1, 2'b00, 6'd5);
      imem[6]  = mty(OP_VLD, 5'd5, 8'd3);
      imem[7]  = rty(5'd6, 5'd5, 5'd2, 3'd0, 2'b00, 6'd6);
      imem[8]  = rty(5'd7, 5'd5, 5'd2, 3'd0, 2'b11, 6'd6);
      imem[9]  = mty(OP_VLD, 5'd12, 8'd4);
      imem[10] = rty(5'd11, 5'd5, 5'd12, 3'd0, 2'b11, 6'd6);
      imem[11] = mty(OP_BNEZ, 5'd0, 8'h10);
      imem[12] = mty(OP_VLD, 5'd8, 8'd1);
      imem[13] = mty(OP_BEZ, 5'd0, 8'h10);
      imem[14] = mty(OP_VLD, 5'd9, 8'd1);
      imem[16] = mty(OP_VLD, 5'd10, 8'd0);
      imem[18] = mty(OP_BEZ, 5'd31, 8'd18);
      for (int i = 0; i < 256; i++) mmem[i] = dmem[i];
      model_run(18);
      release_run(60);

      for (int i = 0; i < 14; i++)
         check($sformatf("fetch%0d", i), 64'(trace[i]), 64'(i + 1));
      check("br_target", 64'(trace[14]), 64'h10);
      check("vadd8", dut.rf.data_arr[3], 64'h0203040506070809);
      check("vmov_upper", dut.rf.data_arr[4], 64'h01020304AAAAAAAA);
      check("vadd8_wrap", dut.rf.data_arr[6], 64'h0);
      check("vadd64_wrap", dut.rf.data_arr[11], 64'h0);
      check("vadd64", dut.rf.data_arr[7], 64'h0101010101010100);
      check("squashed", dut.rf.data_arr[9], 64'h0);
      check("fallthru", dut.rf.data_arr[8], 64'h0101010101010101);
      check("st_cnt", 64'(wr_cnt), 64'd1);
      check("st_addr", 64'(wr_addr), 64'd5);
      check("st_data", wr_data, 64'h0203040506070809);
      check("mem5", dmem[5], 64'h0203040506070809);
      compare_all("dir");

      // Random programs, some interrupted by a mid-run reset.
      for (int run = 0; run < 15; run++) begin
         if (run % 3 == 1) begin
            do_reset();
            gen_prog(halt);
            release_run(halt / 2 + 3);
         end
         do_reset();
         gen_prog(halt);
         for (int i = 0; i < 256; i++) mmem[i] = dmem[i];
         model_run(halt);
         release_run(2 * halt + 20);
         compare_all($sformatf("rnd%0d", run));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
